// File: rtl/optical_rx_deframer_pkg.sv
// Shared definitions for the optical link framer/deframer pair:
// FSM state encoding and the default framing word.
package optical_rx_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } rx_state_t;

   localparam int unsigned DEF_WORD_W    = 8;
   localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;

endpackage

// File: rtl/optical_rx_deframer_if.sv
// Bit-stream input, payload valid/ready output and status flags of the deframer.
interface optical_rx_deframer_if #(
   parameter int unsigned WORD_W = 8
);
   logic              rx_bit_valid;
   logic              rx_bit;
   logic              out_valid;
   logic [WORD_W-1:0] out_data;
   logic              out_ready;
   logic              locked;
   logic              overflow;

   modport master (
      output rx_bit_valid, rx_bit, out_ready,
      input  out_valid, out_data, locked, overflow
   );

   modport slave (
      input  rx_bit_valid, rx_bit, out_ready,
      output out_valid, out_data, locked, overflow
   );
endinterface

// File: rtl/optical_rx_deframer_word_fifo.sv
// Two-entry in-order word buffer; the head entry always sits in 'head' so
// the output data comes straight from a flop.
module rx_word_fifo #(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic              valid,
   output logic [WORD_W-1:0] data,
   output logic              full,
   output logic              empty
);
   logic [1:0]        count, count_n;
   logic [WORD_W-1:0] head, head_n, tail, tail_n;
   logic              do_pop, do_push;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a word when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign data    = head;

   always_comb begin
      count_n = count;
      head_n  = head;
      tail_n  = tail;
      case ({do_push, do_pop})
         2'b01: begin
            head_n  = tail;
            count_n = count - 2'd1;
         end
         2'b10: begin
            if (empty) head_n = push_data;
            else       tail_n = push_data;
            count_n = count + 2'd1;
         end
         2'b11: begin
            if (count == 2'd1) begin
               head_n = push_data;
            end else begin
               head_n = tail;
               tail_n = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
         valid <= 1'b0;
      end else begin
         count <= count_n;
         head  <= head_n;
         tail  <= tail_n;
         valid <= (count_n != 2'd0);
      end
   end
endmodule

// File: rtl/optical_rx_deframer.sv
// Receive word aligner/deframer: hunts for the sync word at any bit offset,
// verifies frame spacing before declaring lock, flywheels over isolated misses.
module optical_rx_deframer
   import optical_rx_pkg::*;
#(
   parameter int unsigned       WORD_W      = DEF_WORD_W,
   parameter logic [WORD_W-1:0] SYNC_WORD   = WORD_W'(DEF_SYNC_WORD),
   parameter int unsigned       FRAME_WORDS = 4,
   parameter int unsigned       LOCK_COUNT  = 3,
   parameter int unsigned       ERR_LIMIT   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   optical_rx_deframer_if.slave bus
);
   localparam int unsigned BIT_W  = $clog2(WORD_W);
   localparam int unsigned WCNT_W = $clog2(FRAME_WORDS);
   localparam int unsigned HIT_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MISS_W = $clog2(ERR_LIMIT + 1);

   rx_state_t         state, state_n;
   // Only the last WORD_W-1 bits are kept; the incoming bit completes the word.
   logic [WORD_W-2:0] shreg, shreg_n;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
   logic [WCNT_W-1:0] word_cnt, word_cnt_n;
   logic [HIT_W-1:0]  hit_cnt, hit_cnt_n, hit_inc;
   logic [MISS_W-1:0] miss_cnt, miss_cnt_n, miss_inc;
   logic              push;
   logic              locked_q, overflow_q;

   logic [WORD_W-1:0] shifted;
   logic              sync_hit, word_done, sync_slot;
   logic              fifo_valid, fifo_full, fifo_empty, pop;
   logic [WORD_W-1:0] fifo_data;

   assign shifted   = {shreg, bus.rx_bit};
   assign sync_hit  = (shifted == SYNC_WORD);
   assign word_done = (bit_cnt == BIT_W'(WORD_W - 1));
   assign sync_slot = (word_cnt == '0);
   assign hit_inc   = (hit_cnt == HIT_W'(LOCK_COUNT)) ? hit_cnt : hit_cnt + HIT_W'(1);
   assign miss_inc  = (miss_cnt == MISS_W'(ERR_LIMIT)) ? miss_cnt : miss_cnt + MISS_W'(1);
   assign pop       = !fifo_empty && bus.out_ready;

   // Next-state and counter update; only valid bits advance the aligner.
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      bit_cnt_n  = bit_cnt;
      word_cnt_n = word_cnt;
      hit_cnt_n  = hit_cnt;
      miss_cnt_n = miss_cnt;
      push       = 1'b0;

      if (bus.rx_bit_valid) begin
         shreg_n   = shifted[WORD_W-2:0];
         bit_cnt_n = word_done ? '0 : bit_cnt + BIT_W'(1);
         if (word_done)
            word_cnt_n = (word_cnt == WCNT_W'(FRAME_WORDS - 1)) ? '0 : word_cnt + WCNT_W'(1);

         case (state)
            HUNT: begin
               bit_cnt_n  = '0;
               word_cnt_n = '0;
               if (sync_hit) begin
                  word_cnt_n = WCNT_W'(1);
                  hit_cnt_n  = HIT_W'(1);
                  miss_cnt_n = '0;
                  state_n    = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               if (word_done && sync_slot) begin
                  if (sync_hit) begin
                     hit_cnt_n = hit_inc;
                     if (hit_inc == HIT_W'(LOCK_COUNT)) begin
                        state_n    = LOCKED;
                        miss_cnt_n = '0;
                     end
                  end else begin
                     state_n    = HUNT;
                     hit_cnt_n  = '0;
                     bit_cnt_n  = '0;
                     word_cnt_n = '0;
                  end
               end
            end
            LOCKED: begin
               if (word_done && sync_slot) begin
                  if (sync_hit) begin
                     miss_cnt_n = '0;
                  end else if (miss_inc == MISS_W'(ERR_LIMIT)) begin
                     state_n    = HUNT;
                     bit_cnt_n  = '0;
                     word_cnt_n = '0;
                     hit_cnt_n  = '0;
                     miss_cnt_n = '0;
                  end else begin
                     miss_cnt_n = miss_inc;
                  end
               end else if (word_done) begin
                  push = 1'b1;
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         shreg      <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         locked_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_cnt_n;
         word_cnt <= word_cnt_n;
         hit_cnt  <= hit_cnt_n;
         miss_cnt <= miss_cnt_n;
         locked_q <= (state_n == LOCKED);
         if (push && fifo_full && !pop) overflow_q <= 1'b1;
      end
   end

   rx_word_fifo #(.WORD_W(WORD_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shifted),
      .pop       (pop),
      .valid     (fifo_valid),
      .data      (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.out_valid = fifo_valid;
   assign bus.out_data  = fifo_data;
   assign bus.locked    = locked_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_optical_rx_deframer.sv
// Scoreboard bench for optical_rx_deframer: a frame-position reference model
// predicts delivered words and status; a negedge monitor compares.
module tb_optical_rx_deframer;
   localparam int W      = 8;
   localparam int F      = 4;
   localparam int LOCK_N = 3;
   localparam int ERR_N  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   optical_rx_deframer_if #(.WORD_W(W)) bus ();

   optical_rx_deframer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: mode 0 hunting, 1 verifying, 2 locked.
   int         m_mode;
   logic [7:0] m_hist;
   int         m_phase;
   int         m_hits;
   int         m_miss;
   logic [7:0] m_fifo[$];
   bit         m_ovf;
   bit         m_locked;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] want_q[$];
   bit         mon_en   = 1'b0;
   bit         rand_rdy = 1'b0;
   bit         rdy      = 1'b1;
   bit         hold_prev = 1'b0;
   logic [7:0] prev_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void model_step(bit r, bit v, bit b, bit rd);
      bit         pop;
      bit         push;
      logic [7:0] w;
      if (r) begin
         m_mode = 0; m_hist = 8'h00; m_phase = 0; m_hits = 0; m_miss = 0;
         m_fifo.delete(); exp_q.delete(); m_ovf = 1'b0; m_locked = 1'b0;
         return;
      end
      pop  = (m_fifo.size() > 0) && rd;
      push = 1'b0;
      w    = 8'h00;
      if (v) begin
         m_hist = {m_hist[6:0], b};
         if (m_mode == 0) begin
            if (m_hist == 8'hA5) begin
               m_phase = W; m_hits = 1; m_miss = 0;
               m_mode  = (LOCK_N == 1) ? 2 : 1;
            end
         end else begin
            m_phase++;
            if (m_phase % W == 0) begin
               if (m_phase == W) begin
                  if (m_mode == 1) begin
                     if (m_hist == 8'hA5) begin
                        m_hits++;
                        if (m_hits >= LOCK_N) begin m_mode = 2; m_miss = 0; end
                     end else begin
                        m_mode = 0; m_hits = 0;
                     end
                  end else begin
                     if (m_hist == 8'hA5) m_miss = 0;
                     else begin
                        m_miss++;
                        if (m_miss >= ERR_N) begin m_mode = 0; m_hits = 0; m_miss = 0; end
                     end
                  end
               end else if (m_mode == 2) begin
                  push = 1'b1;
                  w    = m_hist;
               end
               if (m_phase == W * F) m_phase = 0;
            end
         end
      end
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
         if (m_fifo.size() < 2) begin
            m_fifo.push_back(w);
            exp_q.push_back(w);
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_locked = (m_mode == 2);
   endfunction

   task automatic tick(input bit r, input bit v, input bit b);
      bit rd;
      rd = rand_rdy ? 1'($urandom_range(0, 1)) : rdy;
      rst = r;
      bus.rx_bit_valid = v;
      bus.rx_bit       = b;
      bus.out_ready    = rd;
      @(posedge clk);
      model_step(r, v, b, rd);
      #1;
   endtask

   task automatic send_bit(input bit b, input int gap_pct);
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++)
         tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      tick(1'b0, 1'b1, b);
   endtask

   task automatic send_word(input logic [7:0] w, input int gap_pct);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i], gap_pct);
   endtask

   task automatic send_frame(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input int gap_pct);
      send_word(s, gap_pct); send_word(a, gap_pct); send_word(b, gap_pct); send_word(c, gap_pct);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = 1'b0;
   endtask

   task automatic check_got(input string name);
      check({name, "_count"}, 32'(got_q.size()), 32'(want_q.size()));
      for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
         check(name, 32'(got_q[i]), 32'(want_q[i]));
      got_q.delete();
   endtask

   // Monitor: status every cycle, scoreboard pop on each accepted word.
   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", 32'(bus.out_valid), 32'(m_fifo.size() > 0));
         check("locked", 32'(bus.locked), 32'(m_locked));
         check("overflow", 32'(bus.overflow), 32'(m_ovf));
         if (hold_prev) check("out_data_hold", 32'(bus.out_data), 32'(prev_data));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL out_data: got word %0h, expected no word", bus.out_data);
            end else begin
               check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
            got_q.push_back(bus.out_data);
         end
         hold_prev = bus.out_valid && !bus.out_ready && !rst;
         prev_data = bus.out_data;
      end
   end

   initial begin
      bus.rx_bit_valid = 1'b0;
      bus.rx_bit       = 1'b0;
      bus.out_ready    = 1'b1;

      tick(1'b1, 1'b0, 1'b0);
      mon_en = 1'b1;
      do_reset(3);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_locked", 32'(bus.locked), 32'd0);
      check("reset_overflow", 32'(bus.overflow), 32'd0);

      // Aligned start
      got_q.delete();
      for (int f = 0; f < 3; f++) send_frame(8'hA5, 8'h11, 8'h22, 8'h33, 0);
      send_frame(8'hA5, 8'h44, 8'h55, 8'h66, 0);
      idle(4);
      want_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      check_got("aligned_seq");

      // Arbitrary alignment with gaps
      do_reset(2);
      send_bit(1'b1, 30); send_bit(1'b0, 30); send_bit(1'b1, 30);
      for (int f = 0; f < 3; f++) send_frame(8'hA5, 8'h11, 8'h22, 8'h33, 30);
      send_frame(8'hA5, 8'h44, 8'h55, 8'h66, 30);
      idle(4);
      want_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      check_got("gapped_seq");

      // Flywheel over one miss, lose lock on two
      send_frame(8'h5A, 8'h01, 8'h02, 8'h03, 0);
      idle(3);
      check("flywheel_locked", 32'(bus.locked), 32'd1);
      want_q = '{8'h01, 8'h02, 8'h03};
      check_got("flywheel_seq");
      send_frame(8'hA5, 8'h04, 8'h05, 8'h06, 0);
      send_frame(8'h5A, 8'h07, 8'h08, 8'h09, 0);
      send_word(8'h5A, 0);
      idle(2);
      check("loss_locked", 32'(bus.locked), 32'd0);
      send_word(8'h0A, 0); send_word(8'h0B, 0); send_word(8'h0C, 0);
      idle(3);
      want_q = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
      check_got("loss_seq");
      for (int f = 0; f < 3; f++) send_frame(8'hA5, 8'h21, 8'h22, 8'h23, 0);
      idle(3);
      check("relock_locked", 32'(bus.locked), 32'd1);
      want_q = '{8'h21, 8'h22, 8'h23};
      check_got("relock_seq");

      // Backpressure and sticky overflow
      rdy = 1'b0;
      send_frame(8'hA5, 8'h77, 8'h88, 8'h99, 0);
      idle(4);
      check("bp_overflow", 32'(bus.overflow), 32'd1);
      rdy = 1'b1;
      idle(4);
      want_q = '{8'h77, 8'h88};
      check_got("bp_seq");
      send_frame(8'hA5, 8'h12, 8'h13, 8'h14, 0);
      idle(3);
      check("overflow_sticky", 32'(bus.overflow), 32'd1);
      got_q.delete();

      // Reset mid-word with a buffered word
      rdy = 1'b0;
      send_word(8'hA5, 0); send_word(8'h12, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      do_reset(1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_locked", 32'(bus.locked), 32'd0);
      check("midrst_overflow", 32'(bus.overflow), 32'd0);
      rdy = 1'b1;
      got_q.delete();
      send_frame(8'hA5, 8'h31, 8'h32, 8'h33, 0);
      idle(2);
      check("reacq_not_locked", 32'(bus.locked), 32'd0);
      send_frame(8'hA5, 8'h31, 8'h32, 8'h33, 0);
      send_frame(8'hA5, 8'h41, 8'h42, 8'h43, 0);
      idle(3);
      check("reacq_locked", 32'(bus.locked), 32'd1);
      want_q = '{8'h41, 8'h42, 8'h43};
      check_got("reacq_seq");

      // Random traffic, random gaps and random backpressure
      rand_rdy = 1'b1;
      for (int f = 0; f < 60; f++) begin
         logic [7:0] s;
         s = ($urandom_range(0, 99) < 85) ? 8'hA5 : 8'($urandom);
         send_frame(s, 8'($urandom), 8'($urandom), 8'($urandom), 20);
      end
      rand_rdy = 1'b0;
      rdy = 1'b1;
      idle(10);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
